// File: rtl/leitor_display.sv
// Receive-side monitor for a 4-digit multiplexed 7-segment scan bus.
// Rebuilds the shown digits, debounces them across scans and flags scan faults.
module leitor_display #(
  parameter bit DIG_ATIVO_BAIXO  = 1'b1,
  parameter bit SEG_ATIVO_BAIXO  = 1'b1,
  parameter int QUADROS_ESTAVEIS = 2,
  parameter int TIMEOUT          = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  BITS_DIGITOS,
  input  logic [6:0]  BITS_SEGMENTOS,
  output logic [19:0] DIGITOS,
  output logic [3:0]  VALIDO,
  output logic        QUADRO,
  output logic        ERRO_SCAN,
  output logic        SCAN_PARADO
);

  localparam logic [2:0] QE    = 3'(QUADROS_ESTAVEIS);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT);
  localparam logic [4:0] BLANK = 5'h10;

  // Segment word is active-high here: [6]=a ... [0]=g.
  function automatic logic [4:0] decodifica(input logic [6:0] s);
    case (s)
      7'h7E:   decodifica = 5'h00;
      7'h30:   decodifica = 5'h01;
      7'h6D:   decodifica = 5'h02;
      7'h79:   decodifica = 5'h03;
      7'h33:   decodifica = 5'h04;
      7'h5B:   decodifica = 5'h05;
      7'h5F:   decodifica = 5'h06;
      7'h70:   decodifica = 5'h07;
      7'h7F:   decodifica = 5'h08;
      7'h7B:   decodifica = 5'h09;
      7'h77:   decodifica = 5'h0A;
      7'h1F:   decodifica = 5'h0B;
      7'h4E:   decodifica = 5'h0C;
      7'h3D:   decodifica = 5'h0D;
      7'h4F:   decodifica = 5'h0E;
      7'h47:   decodifica = 5'h0F;
      7'h00:   decodifica = BLANK;
      default: decodifica = 5'h1F;
    endcase
  endfunction

  function automatic logic multiplo(input logic [3:0] s);
    multiplo = (s & (s - 4'd1)) != 4'd0;
  endfunction

  logic [3:0] sel1, sel2;
  logic [6:0] seg1, seg2;
  logic [4:0] cand [4];
  logic [2:0] cnt  [4];
  logic [3:0] seen;
  logic [7:0] parado_cnt;

  logic [4:0] dec;
  logic [3:0] queda;
  logic [3:0] seen_next;
  logic [7:0] parado_next;
  logic [2:0] cnt_next [4];
  logic       igual    [4];

  always_comb begin
    dec       = decodifica(seg2);
    // Sample on the falling select, using the word from the last lit cycle.
    queda     = sel2 & ~sel1 & {4{~multiplo(sel2)}};
    seen_next = seen | queda;
    if (sel1 != sel2) begin
      parado_next = 8'd0;
    end else if (parado_cnt != 8'hFF) begin
      parado_next = parado_cnt + 8'd1;
    end else begin
      parado_next = parado_cnt;
    end
    for (int i = 0; i < 4; i++) begin
      igual[i] = (dec == cand[i]);
      if (!igual[i]) begin
        cnt_next[i] = 3'd1;
      end else if (cnt[i] < QE) begin
        cnt_next[i] = cnt[i] + 3'd1;
      end else begin
        cnt_next[i] = QE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sel1        <= 4'd0;
      sel2        <= 4'd0;
      seg1        <= 7'd0;
      seg2        <= 7'd0;
      seen        <= 4'd0;
      parado_cnt  <= 8'd0;
      DIGITOS     <= {4{BLANK}};
      VALIDO      <= 4'd0;
      QUADRO      <= 1'b0;
      ERRO_SCAN   <= 1'b0;
      SCAN_PARADO <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cand[i] <= BLANK;
        cnt[i]  <= 3'd0;
      end
    end else begin
      sel1        <= BITS_DIGITOS ^ {4{DIG_ATIVO_BAIXO}};
      seg1        <= BITS_SEGMENTOS ^ {7{SEG_ATIVO_BAIXO}};
      sel2        <= sel1;
      seg2        <= seg1;
      parado_cnt  <= parado_next;
      SCAN_PARADO <= (parado_next >= LIMIT);
      if (multiplo(sel1)) begin
        ERRO_SCAN <= 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (queda[i]) begin
          cand[i] <= dec;
          cnt[i]  <= cnt_next[i];
          if (cnt_next[i] == QE) begin
            DIGITOS[5*i +: 5] <= dec;
            VALIDO[i]         <= 1'b1;
          end
        end
      end
      // The completing sample clears the whole mask, its own bit included.
      if (seen_next == 4'hF) begin
        QUADRO <= 1'b1;
        seen   <= 4'd0;
      end else begin
        QUADRO <= 1'b0;
        seen   <= seen_next;
      end
    end
  end

endmodule

// File: tb/tb_leitor_display.sv
// Randomised bench for leitor_display with an event-level reference model.
module tb_leitor_display;
  localparam int QE = 2;
  localparam int TO = 64;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  BITS_DIGITOS;
  logic [6:0]  BITS_SEGMENTOS;
  logic [19:0] DIGITOS;
  logic [3:0]  VALIDO;
  logic        QUADRO;
  logic        ERRO_SCAN;
  logic        SCAN_PARADO;

  always #5 CLK = ~CLK;

  leitor_display #(
    .DIG_ATIVO_BAIXO(1'b1), .SEG_ATIVO_BAIXO(1'b1),
    .QUADROS_ESTAVEIS(QE), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .BITS_DIGITOS(BITS_DIGITOS), .BITS_SEGMENTOS(BITS_SEGMENTOS),
    .DIGITOS(DIGITOS), .VALIDO(VALIDO), .QUADRO(QUADRO),
    .ERRO_SCAN(ERRO_SCAN), .SCAN_PARADO(SCAN_PARADO)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Active-high glyphs abcdefg for 0..F.
  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  function automatic logic [4:0] decode_ref(input logic [6:0] p);
    if (p == 7'd0) return 5'h10;
    for (int k = 0; k < 16; k++) if (glyph[k] == p) return 5'(k);
    return 5'h1F;
  endfunction

  // Reference model: history of the last two normalised input words plus spec rules.
  logic [3:0] h1, h2;
  logic [6:0] s1, s2;
  logic [4:0] m_cand [4];
  int         m_cnt  [4];
  logic [4:0] m_dig  [4];
  logic [3:0] m_val, m_seen;
  logic       m_q, m_err, m_par;
  int         m_scnt;
  logic [4:0] mv;

  always @(posedge CLK) begin
    if (RST) begin
      h1 = 4'd0; h2 = 4'd0; s1 = 7'd0; s2 = 7'd0;
      for (int k = 0; k < 4; k++) begin
        m_cand[k] = 5'h10; m_cnt[k] = 0; m_dig[k] = 5'h10;
      end
      m_val = 4'd0; m_seen = 4'd0; m_q = 1'b0; m_err = 1'b0; m_par = 1'b0; m_scnt = 0;
    end else begin
      m_scnt = (h1 != h2) ? 0 : ((m_scnt < 255) ? m_scnt + 1 : 255);
      m_par  = (m_scnt >= TO);
      if ($countones(h1) > 1) m_err = 1'b1;
      m_q = 1'b0;
      if ($countones(h2) <= 1) begin
        for (int k = 0; k < 4; k++) begin
          if (h2[k] && !h1[k]) begin
            mv = decode_ref(s2);
            if (mv == m_cand[k]) m_cnt[k] = (m_cnt[k] + 1 > QE) ? QE : m_cnt[k] + 1;
            else begin
              m_cand[k] = mv;
              m_cnt[k]  = 1;
            end
            if (m_cnt[k] == QE) begin
              m_dig[k] = mv;
              m_val[k] = 1'b1;
            end
            m_seen[k] = 1'b1;
            if (m_seen == 4'hF) begin
              m_q    = 1'b1;
              m_seen = 4'd0;
            end
          end
        end
      end
      h2 = h1; s2 = s1;
      h1 = ~BITS_DIGITOS; s1 = ~BITS_SEGMENTOS;
    end
  end

  bit mon_en = 1'b0;
  int qcount = 0;

  always @(negedge CLK) begin
    if (mon_en) begin
      check("digitos", DIGITOS, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
      check("valido", VALIDO, m_val);
      check("quadro", QUADRO, m_q);
      check("erro_scan", ERRO_SCAN, m_err);
      check("scan_parado", SCAN_PARADO, m_par);
      if (QUADRO) qcount++;
    end
  end

  logic [6:0] cur_pat [4];

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg);
    @(posedge CLK);
    #1;
    BITS_DIGITOS   = ~sel;
    BITS_SEGMENTOS = ~seg;
  endtask

  task automatic scan(input int n, input int gap);
    for (int d = 0; d < 4; d++) begin
      repeat (n) drive(4'(1 << d), cur_pat[d]);
      repeat (gap) drive(4'd0, 7'd0);
    end
  endtask

  task automatic settle();
    repeat (4) drive(4'd0, 7'd0);
    @(negedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
  endtask

  task automatic set_1234();
    for (int d = 0; d < 4; d++) cur_pat[d] = glyph[d + 1];
  endtask

  function automatic logic [6:0] pat_of(input int code);
    if (code < 16) return glyph[code];
    if (code == 16) return 7'd0;
    return 7'($urandom_range(1, 127));
  endfunction

  int code [4];

  initial begin
    RST = 1'b1;
    BITS_DIGITOS = 4'hF;
    BITS_SEGMENTOS = 7'h7F;
    repeat (3) drive(4'd0, 7'd0);
    mon_en = 1'b1;
    @(negedge CLK); #1;
    check("rst_digitos", DIGITOS, 20'h84210);
    check("rst_valido", VALIDO, 4'd0);
    check("rst_flags", {QUADRO, ERRO_SCAN, SCAN_PARADO}, 3'd0);
    @(posedge CLK); #1; RST = 1'b0;

    // "1234", 8 cycles per digit, three rotations.
    set_1234();
    qcount = 0;
    repeat (3) scan(8, 0);
    settle();
    check("t1_digitos", DIGITOS, {5'd4, 5'd3, 5'd2, 5'd1});
    check("t1_valido", VALIDO, 4'hF);
    check("t1_quadros", 32'(qcount), 32'd3);
    check("t1_erro", ERRO_SCAN, 1'b0);

    // One-scan glitch on digit1 must not commit; two scans must.
    cur_pat[1] = glyph[7];
    scan(6, 1);
    cur_pat[1] = glyph[2];
    scan(6, 1);
    settle();
    check("t2_glitch", DIGITOS[9:5], 5'h02);
    cur_pat[1] = glyph[7];
    repeat (2) scan(6, 1);
    settle();
    check("t2_held", DIGITOS[9:5], 5'h07);

    // Unrecognised pattern and blank digit.
    cur_pat[2] = 7'b1010101;
    cur_pat[3] = 7'd0;
    repeat (2) scan(5, 0);
    settle();
    check("t3_slot2", DIGITOS[14:10], 5'h1F);
    check("t3_slot3", DIGITOS[19:15], 5'h10);
    check("t3_valido", VALIDO[3:2], 2'b11);

    // Multi-select for one cycle: sticky until reset.
    drive(4'b0011, glyph[1]);
    set_1234();
    scan(4, 0);
    settle();
    check("t4_erro_held", ERRO_SCAN, 1'b1);
    pulse_reset();
    @(negedge CLK); #1;
    check("t4_erro_clr", ERRO_SCAN, 1'b0);
    check("t4_digitos_clr", DIGITOS, 20'h84210);

    // Frozen selects for 70 cycles.
    scan(4, 0);
    repeat (70) drive(4'b0001, glyph[1]);
    check("t5_parado", SCAN_PARADO, 1'b1);
    repeat (3) drive(4'b0010, glyph[2]);
    check("t5_resume", SCAN_PARADO, 1'b0);

    // Reset mid-rotation after commits, then recommit.
    repeat (2) scan(4, 0);
    drive(4'b0001, glyph[1]);
    drive(4'b0010, glyph[2]);
    pulse_reset();
    @(negedge CLK); #1;
    check("t6_valido_clr", VALIDO, 4'd0);
    check("t6_digitos_clr", DIGITOS, 20'h84210);
    repeat (2) scan(4, 0);
    settle();
    check("t6_recommit", DIGITOS, {5'd4, 5'd3, 5'd2, 5'd1});
    check("t6_valido", VALIDO, 4'hF);

    // Randomised scanning with occasional faults, stalls and resets.
    for (int d = 0; d < 4; d++) code[d] = $urandom_range(0, 16);
    for (int it = 0; it < 300; it++) begin
      int act;
      act = $urandom_range(0, 99);
      if (act < 80) begin
        for (int d = 0; d < 4; d++) begin
          if ($urandom_range(0, 3) == 0) code[d] = $urandom_range(0, 17);
          cur_pat[d] = pat_of(code[d]);
        end
        scan($urandom_range(1, 6), $urandom_range(0, 2));
      end else if (act < 87) begin
        drive(4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)));
      end else if (act < 93) begin
        repeat ($urandom_range(55, 80)) drive(4'(1 << $urandom_range(0, 3)), glyph[$urandom_range(0, 15)]);
      end else begin
        pulse_reset();
      end
    end
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
